fpsu_div_arb: RTL

- Arbiter and sequencer that shares one iterative FP divide/sqrt engine between the three low-half FP SIMD lanes (u1, u3, u5 issue ports).
- Accepts one request per lane, grants round-robin, and launches the engine with latched operands.
- Waits for completion, then returns the 68-bit result and 14-bit ret flags to the owning lane.
- Handles per-lane flush and stale completions using a 2-bit sequence tag.

---
 rtl/fpsu_div_pkg.sv | 15 +
 rtl/fpsu_rr_pick3.sv | 34 +++
 rtl/fpsu_div_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fpsu_div_pkg.sv
// Shared types and constants for the FP divide/sqrt arbiter.
package fpsu_div_pkg;

   localparam int LANE_N = 3;
   localparam int TAG_W  = 2;
   localparam logic [13:0] RET_TIMEOUT_FLAG = 14'h2000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RET} div_state_t;

   // Reduce a small lane sum (0..5) back into the 0..2 lane range.
   function automatic logic [1:0] lane_wrap(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

endpackage

// File: rtl/fpsu_rr_pick3.sv
// Combinational 3-way round-robin picker: first requester at or above ptr, wrapping 2->0.
module fpsu_rr_pick3
   import fpsu_div_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] cand [LANE_N];

   genvar gi;
   generate
      for (gi = 0; gi < LANE_N; gi++) begin : g_cand
         assign cand[gi] = lane_wrap({1'b0, ptr} + 3'(gi));
      end
   endgenerate

   // Walk candidates from lowest priority to highest so the nearest requester wins.
   always_comb begin
      idx = '0;
      for (int k = LANE_N - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            idx = cand[k];
         end
      end
   end

   assign any = |req;
   assign gnt = any ? (3'b001 << idx) : 3'b000;

endmodule

// File: rtl/fpsu_div_arb.sv
// Shares one iterative FP divide/sqrt engine between lanes u1/u3/u5 with round-robin grant.
// Optional watchdog enabled by defining FPSU_DIV_ARB_TIMEOUT_EN.
module fpsu_div_arb
   import fpsu_div_pkg::*;
#(
   parameter int SIMD_WIDTH = 68,
   parameter int OP_W       = 21,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [LANE_N-1:0]              lane_req,
   input  logic [LANE_N*SIMD_WIDTH-1:0]   lane_A,
   input  logic [LANE_N*SIMD_WIDTH-1:0]   lane_B,
   input  logic [LANE_N*OP_W-1:0]         lane_op,
   input  logic [LANE_N-1:0]              lane_flush,
   output logic [LANE_N-1:0]              lane_gnt,
   output logic                           div_start,
   output logic [SIMD_WIDTH-1:0]          div_A,
   output logic [SIMD_WIDTH-1:0]          div_B,
   output logic [OP_W-1:0]                div_op,
   output logic [TAG_W-1:0]               div_tag,
   input  logic                           div_done,
   input  logic [TAG_W-1:0]               div_done_tag,
   input  logic [SIMD_WIDTH-1:0]          div_res,
   input  logic [13:0]                    div_ret,
   output logic [LANE_N-1:0]              lane_res_en,
   output logic [SIMD_WIDTH-1:0]          lane_res,
   output logic [13:0]                    lane_ret,
   output logic                           busy
);

   logic [SIMD_WIDTH-1:0] a_lane  [LANE_N];
   logic [SIMD_WIDTH-1:0] b_lane  [LANE_N];
   logic [OP_W-1:0]       op_lane [LANE_N];

   genvar gi;
   generate
      for (gi = 0; gi < LANE_N; gi++) begin : g_unpack
         assign a_lane[gi]  = lane_A[SIMD_WIDTH*gi +: SIMD_WIDTH];
         assign b_lane[gi]  = lane_B[SIMD_WIDTH*gi +: SIMD_WIDTH];
         assign op_lane[gi] = lane_op[OP_W*gi +: OP_W];
      end
   endgenerate

   div_state_t            state_reg, state_next;
   logic [1:0]            owner_reg;
   logic [1:0]            rr_ptr_reg;
   logic [TAG_W-1:0]      tag_reg;
   logic                  killed_reg;
   logic [SIMD_WIDTH-1:0] a_reg, b_reg, res_reg;
   logic [OP_W-1:0]       op_reg;
   logic [13:0]           ret_reg;

   logic [2:0] pick_gnt;
   logic [1:0] pick_idx;
   logic       pick_any;

   // A lane being flushed this cycle cannot win the grant.
   fpsu_rr_pick3 u_pick (
      .req (lane_req & ~lane_flush),
      .ptr (rr_ptr_reg),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   logic done_hit, owner_flush, timeout_hit;
   assign done_hit    = (state_reg == WAIT) && div_done && (div_done_tag == tag_reg);
   assign owner_flush = lane_flush[owner_reg];

`ifdef FPSU_DIV_ARB_TIMEOUT_EN
   logic [7:0] wd_cnt_reg;
   assign timeout_hit = (state_reg == WAIT) && (wd_cnt_reg == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state_reg == ISSUE) begin
         wd_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
         wd_cnt_reg <= wd_cnt_reg + 8'd1;
      end
   end
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      lane_gnt    = '0;
      div_start   = 1'b0;
      lane_res_en = '0;
      unique case (state_reg)
         IDLE: begin
            if (pick_any && !rst) begin
               lane_gnt   = pick_gnt;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            div_start  = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (done_hit || timeout_hit) begin
               state_next = RET;
            end
         end
         RET: begin
            if (!killed_reg && !owner_flush) begin
               lane_res_en = 3'b001 << owner_reg;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         owner_reg  <= '0;
         rr_ptr_reg <= '0;
         tag_reg    <= '0;
         killed_reg <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         res_reg    <= '0;
         ret_reg    <= '0;
      end else begin
         state_reg <= state_next;
         unique case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  owner_reg <= pick_idx;
                  a_reg     <= a_lane[pick_idx];
                  b_reg     <= b_lane[pick_idx];
                  op_reg    <= op_lane[pick_idx];
               end
            end
            ISSUE: begin
               if (owner_flush) killed_reg <= 1'b1;
            end
            WAIT: begin
               if (owner_flush) killed_reg <= 1'b1;
               // A real completion wins over a watchdog expiry in the same cycle.
               if (done_hit) begin
                  res_reg <= div_res;
                  ret_reg <= div_ret;
               end else if (timeout_hit) begin
                  res_reg <= '0;
                  ret_reg <= RET_TIMEOUT_FLAG;
               end
            end
            RET: begin
               tag_reg    <= tag_reg + 1'b1;
               rr_ptr_reg <= lane_wrap({1'b0, owner_reg} + 3'd1);
               killed_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign div_A    = a_reg;
   assign div_B    = b_reg;
   assign div_op   = op_reg;
   assign div_tag  = tag_reg;
   assign lane_res = res_reg;
   assign lane_ret = ret_reg;
   assign busy     = (state_reg != IDLE);

endmodule
